// File: rtl/mem_initiator.sv
// Requester-side controller for a single-port synchronous memory: valid/ready
// write and wrapping read-burst commands in, backpressured read beats out.
// Optional build macro MEM_INIT_STATS_EN adds saturating write/read-beat counters.
module mem_initiator #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last,
  output logic                  busy,
`ifdef MEM_INIT_STATS_EN
  output logic [15:0]           wr_count,
  output logic [15:0]           rd_count,
`endif
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_RSP   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_req_ready;
  logic                  r_mem_rd_en;
  logic                  r_mem_wr_en;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [LEN_WIDTH-1:0]  r_cnt;

  logic                  w_accept;
  logic                  w_rsp_hs;
  logic                  w_cnt_zero;
  logic                  w_next_beat;
  logic                  w_rd_en_next;
  logic                  w_wr_en_next;
  logic [ADDR_WIDTH-1:0] w_addr_inc;
  logic [ADDR_WIDTH-1:0] w_mem_addr_next;
  logic [DATA_WIDTH-1:0] w_mem_wdata_next;
  logic [LEN_WIDTH-1:0]  w_cnt_next;

  assign w_accept    = req_valid && r_req_ready;
  assign w_rsp_hs    = (r_state == S_RSP) && rsp_ready;
  assign w_cnt_zero  = (r_cnt == '0);
  assign w_next_beat = w_rsp_hs && !w_cnt_zero;
  // DEPTH is a power of two, so the natural overflow of the add is the wrap.
  assign w_addr_inc  = r_mem_addr + ADDR_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = req_write ? S_WRITE : S_READ;
        end
      end
      S_WRITE: w_state_next = S_IDLE;
      S_READ:  w_state_next = S_RSP;
      S_RSP: begin
        if (w_rsp_hs) begin
          w_state_next = w_cnt_zero ? S_IDLE : S_READ;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy             = (r_state != S_IDLE);
    rsp_valid        = (r_state == S_RSP);
    rsp_last         = (r_state == S_RSP) && w_cnt_zero;
    rsp_data         = mem_rdata;
    w_wr_en_next     = w_accept && req_write;
    w_rd_en_next     = (w_accept && !req_write) || w_next_beat;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_cnt_next       = r_cnt;
    if (w_accept) begin
      w_mem_addr_next = req_addr;
      if (req_write) begin
        w_mem_wdata_next = req_wdata;
      end else begin
        w_cnt_next = req_len;
      end
    end else if (w_next_beat) begin
      w_mem_addr_next = w_addr_inc;
      w_cnt_next      = r_cnt - LEN_WIDTH'(1);
    end
  end

  // Memory pins are registered so the memory sees clean, glitch-free controls;
  // mem_addr doubles as the burst address register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready <= 1'b0;
      r_mem_rd_en <= 1'b0;
      r_mem_wr_en <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cnt       <= '0;
    end else begin
      r_req_ready <= (w_state_next == S_IDLE);
      r_mem_rd_en <= w_rd_en_next;
      r_mem_wr_en <= w_wr_en_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_cnt       <= w_cnt_next;
    end
  end

  assign req_ready = r_req_ready;
  assign mem_rd_en = r_mem_rd_en;
  assign mem_wr_en = r_mem_wr_en;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

`ifdef MEM_INIT_STATS_EN
  logic [15:0] r_wr_count;
  logic [15:0] r_rd_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_count <= '0;
      r_rd_count <= '0;
    end else begin
      if (w_wr_en_next && (r_wr_count != 16'hFFFF)) begin
        r_wr_count <= r_wr_count + 16'd1;
      end
      if (w_rsp_hs && (r_rd_count != 16'hFFFF)) begin
        r_rd_count <= r_rd_count + 16'd1;
      end
    end
  end

  assign wr_count = r_wr_count;
  assign rd_count = r_rd_count;
`endif

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator with a behavioural single-port memory behind it.
// Table-driven single-beat traffic plus hand-written burst, backpressure and reset cases.
`timescale 1ns/1ps
module tb_mem_initiator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [2:0] req_addr = 3'd0;
  logic [7:0] req_wdata = 8'd0;
  logic [2:0] req_len = 3'd0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_last;
  logic       busy;
  logic       mem_rd_en;
  logic       mem_wr_en;
  logic [2:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'd0;
`ifdef MEM_INIT_STATS_EN
  logic [15:0] wr_count;
  logic [15:0] rd_count;
  int          wr_seen = 0;
  int          rd_seen = 0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_beats [8];
  logic [7:0] mem_array [8];

  always #5 clk = ~clk;

  mem_initiator #(.DATA_WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .busy(busy),
`ifdef MEM_INIT_STATS_EN
    .wr_count(wr_count), .rd_count(rd_count),
`endif
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Single-port synchronous memory: registered read that holds while rd_en is low.
  always @(posedge clk) begin
    if (mem_wr_en) mem_array[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem_array[mem_addr];
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    check("req_ready_wait", int'(req_ready), 1);
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0; req_addr = ~a; req_wdata = ~d;
    check("wr_en_on", int'(mem_wr_en), 1);
    check("wr_rd_excl", int'(mem_rd_en), 0);
    check("wr_addr", int'(mem_addr), int'(a));
    check("wr_data", int'(mem_wdata), int'(d));
    check("wr_busy", int'(busy), 1);
    tick();
    check("wr_en_off", int'(mem_wr_en), 0);
    check("wr_ready_back", int'(req_ready), 1);
`ifdef MEM_INIT_STATS_EN
    wr_seen++;
`endif
    $display("write addr=%0d data=0x%02h", a, d);
  endtask

  // Beats are compared against exp_beats[]; abort_after>0 returns right after that many beats.
  task automatic read_burst(input logic [2:0] a, input logic [2:0] len,
                            input int stall, input int abort_after);
    logic [2:0] cur;
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = len;
    tick();
    req_valid = 1'b0; req_addr = a + 3'd3; req_len = 3'd0;
    check("rd_issue_en", int'(mem_rd_en), 1);
    check("rd_issue_addr", int'(mem_addr), int'(a));
    check("rd_issue_novalid", int'(rsp_valid), 0);
    cur = a;
    for (int b = 0; b <= int'(len); b++) begin
      tick();
      check("rsp_valid_latency", int'(rsp_valid), 1);
      check("rsp_no_rd_en", int'(mem_rd_en), 0);
      for (int s = 0; s < stall; s++) begin
        check("stall_data", int'(rsp_data), int'(exp_beats[b]));
        check("stall_last", int'(rsp_last), int'(b == int'(len)));
        check("stall_valid", int'(rsp_valid), 1);
        check("stall_no_rd_en", int'(mem_rd_en), 0);
        tick();
      end
      check("rsp_data", int'(rsp_data), int'(exp_beats[b]));
      check("rsp_last", int'(rsp_last), int'(b == int'(len)));
      $display("read beat %0d addr=%0d data=0x%02h last=%0d", b, cur, rsp_data, rsp_last);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
`ifdef MEM_INIT_STATS_EN
      rd_seen++;
`endif
      cur = cur + 3'd1;
      if (b < int'(len)) begin
        check("next_rd_en", int'(mem_rd_en), 1);
        check("next_rd_addr", int'(mem_addr), int'(cur));
        check("next_novalid", int'(rsp_valid), 0);
        if (abort_after > 0 && b + 1 == abort_after) return;
      end else begin
        check("end_idle_busy", int'(busy), 0);
        check("end_rsp_valid", int'(rsp_valid), 0);
        check("end_req_ready", int'(req_ready), 1);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, int'(req_ready), 0);
    check({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    check({tag, "_rsp_last"}, int'(rsp_last), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_rd_en"}, int'(mem_rd_en), 0);
    check({tag, "_wr_en"}, int'(mem_wr_en), 0);
    check({tag, "_addr"}, int'(mem_addr), 0);
    check({tag, "_wdata"}, int'(mem_wdata), 0);
  endtask

  typedef struct {
    bit         wr;
    logic [2:0] addr;
    logic [7:0] data;   // write data, or expected read data
  } vec_t;

  vec_t vecs [14];

  initial begin
    vecs[0]  = '{1'b1, 3'd0, 8'h10};
    vecs[1]  = '{1'b1, 3'd1, 8'h11};
    vecs[2]  = '{1'b1, 3'd2, 8'h12};
    vecs[3]  = '{1'b1, 3'd3, 8'h13};
    vecs[4]  = '{1'b1, 3'd4, 8'h14};
    vecs[5]  = '{1'b1, 3'd5, 8'h15};
    vecs[6]  = '{1'b1, 3'd6, 8'h16};
    vecs[7]  = '{1'b1, 3'd7, 8'h17};
    vecs[8]  = '{1'b1, 3'd3, 8'hA5};
    vecs[9]  = '{1'b0, 3'd3, 8'hA5};
    vecs[10] = '{1'b0, 3'd0, 8'h10};
    vecs[11] = '{1'b0, 3'd7, 8'h17};
    vecs[12] = '{1'b1, 3'd5, 8'h5A};
    vecs[13] = '{1'b0, 3'd5, 8'h5A};

    // Power-on reset held for three cycles
    rst_n = 1'b0;
    repeat (3) tick();
    check_reset_outputs("por");
    rst_n = 1'b1;
    tick();
    check("por_ready_after", int'(req_ready), 1);
    check("por_busy_after", int'(busy), 0);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data);
      end else begin
        exp_beats[0] = vecs[i].data;
        read_burst(vecs[i].addr, 3'd0, 0, 0);
      end
    end

    // Memory now: 10 11 12 A5 14 5A 16 17
    exp_beats[0] = 8'h16; exp_beats[1] = 8'h17;
    exp_beats[2] = 8'h10; exp_beats[3] = 8'h11;
    read_burst(3'd6, 3'd3, 0, 0);

    exp_beats[0] = 8'h12; exp_beats[1] = 8'hA5;
    read_burst(3'd2, 3'd1, 5, 0);

    exp_beats[0] = 8'h14; exp_beats[1] = 8'h5A; exp_beats[2] = 8'h16; exp_beats[3] = 8'h17;
    exp_beats[4] = 8'h10; exp_beats[5] = 8'h11; exp_beats[6] = 8'h12; exp_beats[7] = 8'hA5;
    read_burst(3'd4, 3'd7, 1, 0);

`ifdef MEM_INIT_STATS_EN
    check("wr_count", int'(wr_count), wr_seen);
    check("rd_count", int'(rd_count), rd_seen);
`endif

    // Reset in the middle of a full-length burst
    exp_beats[0] = 8'h10; exp_beats[1] = 8'h11; exp_beats[2] = 8'h12; exp_beats[3] = 8'hA5;
    exp_beats[4] = 8'h14; exp_beats[5] = 8'h5A; exp_beats[6] = 8'h16; exp_beats[7] = 8'h17;
    read_burst(3'd0, 3'd7, 0, 2);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    $display("reset asserted mid-burst");
    repeat (3) tick();
    check_reset_outputs("midrst_hold");
    rst_n = 1'b1;
    tick();
    check("midrst_ready_after", int'(req_ready), 1);
    check("midrst_no_stale", int'(rsp_valid), 0);
    check("midrst_busy_after", int'(busy), 0);
`ifdef MEM_INIT_STATS_EN
    check("wr_count_rst", int'(wr_count), 0);
    check("rd_count_rst", int'(rd_count), 0);
    wr_seen = 0; rd_seen = 0;
`endif
    exp_beats[0] = 8'h10;
    read_burst(3'd0, 3'd0, 0, 0);

`ifdef MEM_INIT_STATS_EN
    do_write(3'd1, 8'h21);
    do_write(3'd2, 8'h22);
    do_write(3'd3, 8'h23);
    exp_beats[0] = 8'h10; exp_beats[1] = 8'h21; exp_beats[2] = 8'h22;
    exp_beats[3] = 8'h23; exp_beats[4] = 8'h14;
    read_burst(3'd0, 3'd4, 0, 0);
    check("wr_count_final", int'(wr_count), 3);
    check("rd_count_final", int'(rd_count), 6);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
Requester-side controller that drives the single-port synchronous memory's rd_en/wr_en/addr/data_in pins and captures its registered data_out. It accepts commands over a valid/ready request channel: single-beat writes, and read bursts of 1..DEPTH beats with a wrapping address. Read data is returned over a valid/ready response channel with backpressure. It sits between bus-facing logic and the memory instance, so no client drives the memory pins directly.

Parameters:
DATA_WIDTH, 8, width of memory word and of req_wdata/rsp_data
DEPTH, 8, number of memory words; power of two, >= 2
ADDR_WIDTH, $clog2(DEPTH), width of every address field
LEN_WIDTH, $clog2(DEPTH), width of req_len (beats minus one)

Ports:
clk  input  1  clock; all logic on the rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid && req_ready at a clk edge
req_write  input  1  1 = write, 0 = read burst
req_addr  input  ADDR_WIDTH  start address
req_wdata  input  DATA_WIDTH  write data; ignored for reads
req_len  input  LEN_WIDTH  read beats minus one; ignored for writes
rsp_valid  output  1  read data beat present
rsp_ready  input  1  beat consumed when rsp_valid && rsp_ready at a clk edge
rsp_data  output  DATA_WIDTH  read data beat
rsp_last  output  1  final beat of a burst, qualified by rsp_valid
busy  output  1  high in any state other than IDLE
mem_rd_en  output  1  to memory rd_en
mem_wr_en  output  1  to memory wr_en
mem_addr  output  ADDR_WIDTH  to memory addr
mem_wdata  output  DATA_WIDTH  to memory data_in
mem_rdata  input  DATA_WIDTH  from memory data_out; registered, valid the cycle after rd_en is sampled

Behaviour:
- Reset, asynchronous: state=IDLE; req_ready=0, rsp_valid=0, rsp_last=0, busy=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0; beat counter=0. All memory-side outputs are registered.
- Reset mid-operation aborts the burst, discards pending beats and produces no response. The first cycle after reset release is IDLE with req_ready=1.
- req_ready=1 only in IDLE. mem_rd_en and mem_wr_en are never high in the same cycle.
- IDLE, on accepting a write: register addr/wdata onto mem_*, mem_wr_en=1 for exactly one cycle (WRITE), then return to IDLE. The next request can be accepted 2 cycles after the previous acceptance. A write produces no response.
- IDLE, on accepting a read: latch addr, cnt=req_len, go to READ.
- READ, one cycle: mem_rd_en=1, mem_addr=current addr. Next state is RSP.
- RSP: rsp_valid=1, rsp_data=mem_rdata, rsp_last=(cnt==0). The memory holds data_out while rd_en=0, so the beat stays stable under backpressure.
  - On handshake with cnt!=0: addr=(addr+1) mod DEPTH, wrapping DEPTH-1 to 0; cnt-=1; go to READ.
  - On handshake with cnt==0: go to IDLE.
- Issue-to-beat latency is 2 cycles: acceptance edge, then the READ edge, then rsp_valid. Throughput is at most 1 beat per 2 cycles.
- rsp_valid is never dropped without a handshake. rsp_data and rsp_last are stable while rsp_valid=1 && rsp_ready=0.
- req_len = DEPTH-1 reads every word exactly once, starting at req_addr.
- req_* inputs are sampled only at acceptance. Changes at other times have no effect.

Optional Feature:
MEM_INIT_STATS_EN:
- Defined: adds outputs wr_count [15:0] and rd_count [15:0]. wr_count increments once per write issued. rd_count increments once per read beat handshaken on the response channel. Both reset to 0 and saturate at 16'hFFFF.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> every output 0; first edge after release shows req_ready=1, busy=0.
- Write then read: write addr 3 data 8'hA5; read addr 3 len 0 -> one beat, rsp_data=8'hA5, rsp_last=1; rsp_valid rises 2 cycles after read acceptance; mem_wr_en high exactly 1 cycle.
- Wrapping burst: write 8'h10..8'h17 to addr 0..7; read addr 6 len 3 -> beats 8'h16, 8'h17, 8'h10, 8'h11; rsp_last only on 8'h11.
- Backpressure: read len 1 with rsp_ready=0 for 5 cycles on each beat -> rsp_data stable, no second mem_rd_en before the first handshake, exactly 2 beats delivered.
- Reset mid-burst: read len 7, assert rst_n=0 after beat 2 -> outputs 0 at once; after release, a new read of addr 0 returns the correct word and no stale beats appear.
- Stats, with MEM_INIT_STATS_EN: 3 writes plus a len-4 read -> wr_count=3, rd_count=5.
